// File: rtl/clock_time_ctrl_pkg.sv
// Shared mode encodings and field limits for the clock timekeeping path.
// Imported by the controller and available to the display formatter.
package clock_time_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_RUN     = 2'd0,
      MODE_SET_HR  = 2'd1,
      MODE_SET_MIN = 2'd2,
      MODE_BAD     = 2'd3
   } mode_e;

   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;

   // The unused encoding always falls back to RUN.
   function automatic mode_e next_mode(input mode_e cur);
      mode_e nxt;
      case (cur)
         MODE_RUN:     nxt = MODE_SET_HR;
         MODE_SET_HR:  nxt = MODE_SET_MIN;
         MODE_SET_MIN: nxt = MODE_RUN;
         default:      nxt = MODE_RUN;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/clock_time_ctrl_wrap_counter.sv
// Modulo-(MAX+1) up/down counter with synchronous clear; one-cycle update.
// Priority: clr, then inc_en, then dec_en; caller never asserts inc and dec together.
module wrap_counter #(
   parameter int MAX = 59
) (
   input  logic       clk_in,
   input  logic       reset_in,
   input  logic       inc_en,
   input  logic       dec_en,
   input  logic       clr,
   output logic [7:0] count_out,
   output logic       at_max
);

   localparam logic [7:0] MAX_V = 8'(MAX);

   logic [7:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = 8'd0;
      end else if (inc_en) begin
         count_d = (count_q == MAX_V) ? 8'd0 : count_q + 8'd1;
      end else if (dec_en) begin
         count_d = (count_q == 8'd0) ? MAX_V : count_q - 8'd1;
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_out = count_q;
   assign at_max    = (count_q == MAX_V);

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping controller: sec/min/hour counters with carry and a RUN/SET_HR/SET_MIN mode FSM.
// All outputs registered; an input pulse at edge N shows on the outputs right after edge N.
module clock_time_ctrl
   import clock_time_ctrl_pkg::*;
#(
   parameter int HOUR_MAX = 23
) (
   input  logic       clk_in,
   input  logic       reset_in,
   input  logic       tick_in,
   input  logic       mode_btn_in,
   input  logic       inc_btn_in,
   input  logic       dec_btn_in,
   output logic [7:0] sec_out,
   output logic [7:0] min_out,
   output logic [7:0] hour_out,
   output logic [1:0] mode_out,
   output logic       blink_out
);

   mode_e mode_d, mode_q;
   logic  blink_d, blink_q;

   logic run, set_hr, set_min;
   logic edit_ok, run_tick;
   logic sec_at_max, min_at_max;
   logic sec_inc, sec_clr;
   logic min_inc, min_dec;
   logic hour_inc, hour_dec;

   assign run     = (mode_q == MODE_RUN);
   assign set_hr  = (mode_q == MODE_SET_HR);
   assign set_min = (mode_q == MODE_SET_MIN);

   // A mode press swallows any edit; opposing edits cancel each other.
   assign edit_ok  = !mode_btn_in && (inc_btn_in ^ dec_btn_in);
   assign run_tick = run && tick_in;

   assign sec_inc  = run_tick;
   assign sec_clr  = set_min && mode_btn_in;
   assign min_inc  = (run_tick && sec_at_max) || (set_min && edit_ok && inc_btn_in);
   assign min_dec  = set_min && edit_ok && dec_btn_in;
   assign hour_inc = (run_tick && sec_at_max && min_at_max) || (set_hr && edit_ok && inc_btn_in);
   assign hour_dec = set_hr && edit_ok && dec_btn_in;

   always_comb begin
      mode_d  = mode_q;
      blink_d = blink_q;
      if (mode_q == MODE_BAD) begin
         mode_d = MODE_RUN;
      end else if (mode_btn_in) begin
         mode_d = next_mode(mode_q);
      end
      if (mode_d != mode_q || run) begin
         blink_d = 1'b0;
      end else if (tick_in && (set_hr || set_min)) begin
         blink_d = !blink_q;
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         mode_q  <= MODE_RUN;
         blink_q <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         blink_q <= blink_d;
      end
   end

   wrap_counter #(.MAX(SEC_MAX)) u_sec (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .inc_en    (sec_inc),
      .dec_en    (1'b0),
      .clr       (sec_clr),
      .count_out (sec_out),
      .at_max    (sec_at_max)
   );

   wrap_counter #(.MAX(MIN_MAX)) u_min (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .inc_en    (min_inc),
      .dec_en    (min_dec),
      .clr       (1'b0),
      .count_out (min_out),
      .at_max    (min_at_max)
   );

   wrap_counter #(.MAX(HOUR_MAX)) u_hour (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .inc_en    (hour_inc),
      .dec_en    (hour_dec),
      .clr       (1'b0),
      .count_out (hour_out),
      .at_max    ()
   );

   assign mode_out  = mode_q;
   assign blink_out = blink_q;

endmodule
